// File: rtl/bounce_multi_if.sv
// Load channel, read port and bounce event outputs of the multi-object bounce engine.
// The master side (frame/pixel logic) drives loads and read selects; the slave side is the engine.
interface bounce_multi_if #(
   parameter int N_OBJ = 4,
   parameter int W     = 8,
   parameter int SPD_W = 3
);
   localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

   logic             load;
   logic             load_ready;
   logic [IDX_W-1:0] load_idx;
   logic [W-1:0]     load_x;
   logic [W-1:0]     load_y;
   logic             load_dx;
   logic             load_dy;
   logic [SPD_W-1:0] load_spd;
   logic [IDX_W-1:0] rd_idx;
   logic [W-1:0]     rd_x;
   logic [W-1:0]     rd_y;
   logic             bounce_x;
   logic             bounce_y;
   logic [IDX_W-1:0] bounce_idx;

   modport master (
      output load, load_idx, load_x, load_y, load_dx, load_dy, load_spd, rd_idx,
      input  load_ready, rd_x, rd_y, bounce_x, bounce_y, bounce_idx
   );

   modport slave (
      input  load, load_idx, load_x, load_y, load_dx, load_dy, load_spd, rd_idx,
      output load_ready, rd_x, rd_y, bounce_x, bounce_y, bounce_idx
   );
endinterface

// File: rtl/bounce_multi_core.sv
// Multi-object bounce engine: on each frame tick, steps N_OBJ objects one per cycle,
// reflecting them at the field walls and reporting bounce, done and overrun events.
module bounce_multi_core #(
   parameter int N_OBJ = 4,
   parameter int W     = 8,
   parameter int LIM_X = 159,
   parameter int LIM_Y = 119,
   parameter int SPD_W = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic tick,
   input  logic clr_ovr,
   output logic busy,
   output logic done,
   output logic overrun,
   bounce_multi_if.slave bus
);
   localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OBJ - 1);
   localparam logic [W-1:0] LX = W'(LIM_X);
   localparam logic [W-1:0] LY = W'(LIM_Y);

   typedef enum logic {S_IDLE, S_SWEEP} state_t;
   typedef struct packed {
      logic [W-1:0] pos;
      logic         dir;
      logic         bnc;
   } axis_t;

   // One axis step in W+1 bits so p+s cannot wrap before the wall compare.
   function automatic axis_t axis_step(logic [W-1:0] pos, logic dir,
                                       logic [SPD_W-1:0] spd, logic [W-1:0] lim);
      logic [W:0] p;
      logic [W:0] s;
      axis_t r;
      p = {1'b0, pos};
      s = (W+1)'(spd);
      r.pos = pos;
      r.dir = dir;
      r.bnc = 1'b0;
      if (spd != '0) begin
         if (!dir) begin
            if (p + s >= {1'b0, lim}) begin
               r.pos = lim;
               r.dir = 1'b1;
               r.bnc = 1'b1;
            end else begin
               r.pos = W'(p + s);
            end
         end else begin
            if (p <= s) begin
               r.pos = '0;
               r.dir = 1'b0;
               r.bnc = 1'b1;
            end else begin
               r.pos = W'(p - s);
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] clamp(logic [W-1:0] v, logic [W-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     x_q [N_OBJ];
   logic [W-1:0]     x_d [N_OBJ];
   logic [W-1:0]     y_q [N_OBJ];
   logic [W-1:0]     y_d [N_OBJ];
   logic [SPD_W-1:0] spd_q [N_OBJ];
   logic [SPD_W-1:0] spd_d [N_OBJ];
   logic [N_OBJ-1:0] dx_q, dx_d, dy_q, dy_d;
   logic             done_q, done_d, ovr_q, ovr_d;
   logic             bx_q, bx_d, by_q, by_d;
   logic [IDX_W-1:0] bidx_q, bidx_d;
   logic             load_rdy, sweep_last, load_ok;
   axis_t            ax, ay;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (ena) begin
         case (state_q)
            S_IDLE: begin
               if (tick) begin
                  state_d = S_SWEEP;
                  cnt_d   = '0;
               end
            end
            S_SWEEP: begin
               if (cnt_q == LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy       = (state_q == S_SWEEP);
      load_rdy   = (state_q == S_IDLE);
      sweep_last = (state_q == S_SWEEP) && (cnt_q == LAST);
   end

   assign load_ok = ena && load_rdy && bus.load && (32'(bus.load_idx) < N_OBJ);

   // A load and a tick in the same idle cycle land before the sweep reads object state.
   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      spd_d  = spd_q;
      dx_d   = dx_q;
      dy_d   = dy_q;
      done_d = done_q;
      ovr_d  = ovr_q;
      bx_d   = bx_q;
      by_d   = by_q;
      bidx_d = bidx_q;
      ax     = '0;
      ay     = '0;
      if (ena) begin
         done_d = sweep_last;
         bx_d   = 1'b0;
         by_d   = 1'b0;
         if (clr_ovr) ovr_d = 1'b0;
         if (tick && busy) ovr_d = 1'b1;
         if (load_ok) begin
            x_d[bus.load_idx]   = clamp(bus.load_x, LX);
            y_d[bus.load_idx]   = clamp(bus.load_y, LY);
            dx_d[bus.load_idx]  = bus.load_dx;
            dy_d[bus.load_idx]  = bus.load_dy;
            spd_d[bus.load_idx] = bus.load_spd;
         end
         if (busy) begin
            ax = axis_step(x_q[cnt_q], dx_q[cnt_q], spd_q[cnt_q], LX);
            ay = axis_step(y_q[cnt_q], dy_q[cnt_q], spd_q[cnt_q], LY);
            x_d[cnt_q]  = ax.pos;
            y_d[cnt_q]  = ay.pos;
            dx_d[cnt_q] = ax.dir;
            dy_d[cnt_q] = ay.dir;
            bx_d   = ax.bnc;
            by_d   = ay.bnc;
            bidx_d = cnt_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_OBJ; i++) begin
            x_q[i]   <= '0;
            y_q[i]   <= '0;
            spd_q[i] <= SPD_W'(1);
         end
         dx_q   <= '0;
         dy_q   <= '0;
         done_q <= 1'b0;
         ovr_q  <= 1'b0;
         bx_q   <= 1'b0;
         by_q   <= 1'b0;
         bidx_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         spd_q  <= spd_d;
         dx_q   <= dx_d;
         dy_q   <= dy_d;
         done_q <= done_d;
         ovr_q  <= ovr_d;
         bx_q   <= bx_d;
         by_q   <= by_d;
         bidx_q <= bidx_d;
      end
   end

   assign done           = done_q;
   assign overrun        = ovr_q;
   assign bus.load_ready = load_rdy;
   assign bus.bounce_x   = bx_q;
   assign bus.bounce_y   = by_q;
   assign bus.bounce_idx = bidx_q;
   assign bus.rd_x       = (32'(bus.rd_idx) < N_OBJ) ? x_q[bus.rd_idx] : '0;
   assign bus.rd_y       = (32'(bus.rd_idx) < N_OBJ) ? y_q[bus.rd_idx] : '0;
endmodule

// File: tb/tb_bounce_multi_core.sv
// Bench for bounce_multi_core: directed scenarios plus random traffic, checked by a
// scoreboard of expected bounce/done events built from a whole-sweep reference model.
`timescale 1ns/100ps
module tb_bounce_multi_core;
   localparam int N_OBJ = 4;
   localparam int W     = 8;
   localparam int LIM_X = 159;
   localparam int LIM_Y = 119;
   localparam int SPD_W = 3;
   localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

   typedef struct {
      int cyc;
      int idx;
      bit bx;
      bit by;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n, ena, tick, clr_ovr;
   logic busy, done, overrun;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   bit   pre_en = 1'b0;

   int   mx [N_OBJ];
   int   my [N_OBJ];
   int   mdx [N_OBJ];
   int   mdy [N_OBJ];
   int   mspd [N_OBJ];
   bit   mov;
   int   busy_start = -10;
   int   busy_end = -10;
   ev_t  evq [$];
   int   doneq [$];
   ev_t  e;

   bounce_multi_if #(.N_OBJ(N_OBJ), .W(W), .SPD_W(SPD_W)) bus ();

   bounce_multi_core #(.N_OBJ(N_OBJ), .W(W), .LIM_X(LIM_X), .LIM_Y(LIM_Y), .SPD_W(SPD_W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .clr_ovr(clr_ovr),
      .busy(busy), .done(done), .overrun(overrun), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endfunction

   task automatic axis(inout int p, inout int d, input int s, input int lim, output bit b);
      b = 1'b0;
      if (s == 0) return;
      if (d == 0) begin
         if (p + s >= lim) begin p = lim; d = 1; b = 1'b1; end
         else p = p + s;
      end else begin
         if (p <= s) begin p = 0; d = 0; b = 1'b1; end
         else p = p - s;
      end
   endtask

   task automatic model_reset(input int c);
      ev_t keep [$];
      int  dk [$];
      for (int i = 0; i < N_OBJ; i++) begin
         mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0; mspd[i] = 1;
      end
      mov = 1'b0;
      foreach (evq[k]) if (evq[k].cyc <= c) keep.push_back(evq[k]);
      foreach (doneq[k]) if (doneq[k] <= c) dk.push_back(doneq[k]);
      evq = keep;
      doneq = dk;
      if (busy_end > c) busy_end = c;
   endtask

   // Applies this cycle's inputs to the model; a whole sweep is resolved at the accepting tick.
   task automatic model_apply();
      int c;
      bit bsy, bxb, byb;
      int li;
      c = cyc;
      bsy = (busy_start < c) && (c <= busy_end);
      if (!rst_n) begin
         model_reset(c);
         return;
      end
      if (!ena) return;
      if (clr_ovr) mov = 1'b0;
      if (tick && bsy) mov = 1'b1;
      li = int'(bus.load_idx);
      if (!bsy && bus.load && li < N_OBJ) begin
         mx[li]   = (int'(bus.load_x) > LIM_X) ? LIM_X : int'(bus.load_x);
         my[li]   = (int'(bus.load_y) > LIM_Y) ? LIM_Y : int'(bus.load_y);
         mdx[li]  = int'(bus.load_dx);
         mdy[li]  = int'(bus.load_dy);
         mspd[li] = int'(bus.load_spd);
      end
      if (!bsy && tick) begin
         for (int i = 0; i < N_OBJ; i++) begin
            axis(mx[i], mdx[i], mspd[i], LIM_X, bxb);
            axis(my[i], mdy[i], mspd[i], LIM_Y, byb);
            if (bxb || byb) evq.push_back('{c + 2 + i, i, bxb, byb});
         end
         doneq.push_back(c + N_OBJ + 1);
         busy_start = c;
         busy_end   = c + N_OBJ;
      end
   endtask

   task automatic step_cyc();
      int  r;
      bit  bsy;
      if (pre_en) begin
         bsy = (busy_start < cyc) && (cyc <= busy_end);
         chk("overrun", overrun, mov);
         chk("load_ready", bus.load_ready, !bsy);
         if (cyc > busy_end) begin
            r = $urandom_range(0, N_OBJ - 1);
            bus.rd_idx = IDX_W'(r);
            #1;
            chk("rd_x", bus.rd_x, mx[r]);
            chk("rd_y", bus.rd_y, my[r]);
         end
      end
      model_apply();
      @(posedge clk);
      #1;
      tick = 1'b0;
      bus.load = 1'b0;
      clr_ovr = 1'b0;
   endtask

   task automatic run_idle();
      int n;
      n = 0;
      while (cyc <= busy_end + 1 && n < 50) begin
         step_cyc();
         n++;
      end
      if (cyc <= busy_end + 1) chk("idle_timeout", 0, 1);
   endtask

   task automatic check_all();
      for (int i = 0; i < N_OBJ; i++) begin
         bus.rd_idx = IDX_W'(i);
         #1;
         chk("obj_x", bus.rd_x, mx[i]);
         chk("obj_y", bus.rd_y, my[i]);
      end
   endtask

   task automatic rd_exp(string nm, int i, int ex, int ey);
      bus.rd_idx = IDX_W'(i);
      #1;
      chk({nm, "_x"}, bus.rd_x, ex);
      chk({nm, "_y"}, bus.rd_y, ey);
   endtask

   task automatic set_load(int i, int x, int y, int dx, int dy, int spd);
      bus.load     = 1'b1;
      bus.load_idx = IDX_W'(i);
      bus.load_x   = W'(x);
      bus.load_y   = W'(y);
      bus.load_dx  = dx[0];
      bus.load_dy  = dy[0];
      bus.load_spd = SPD_W'(spd);
   endtask

   // Scoreboard monitor: pops expected events as the DUT presents pulses.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy", busy, (busy_start < cyc) && (cyc <= busy_end));
         while (evq.size() > 0 && evq[0].cyc < cyc) begin
            chk("bounce_missing", 0, 1);
            void'(evq.pop_front());
         end
         if (bus.bounce_x === 1'b1 || bus.bounce_y === 1'b1) begin
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
               e = evq.pop_front();
               chk("bounce_idx", bus.bounce_idx, e.idx);
               chk("bounce_x", bus.bounce_x, e.bx);
               chk("bounce_y", bus.bounce_y, e.by);
            end else begin
               chk("bounce_unexpected", {bus.bounce_x, bus.bounce_y}, 0);
            end
         end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
            chk("bounce_missing", 0, 1);
            void'(evq.pop_front());
         end
         while (doneq.size() > 0 && doneq[0] < cyc) begin
            chk("done_missing", 0, 1);
            void'(doneq.pop_front());
         end
         if (done === 1'b1) begin
            chk("done_cycle", cyc, (doneq.size() > 0) ? doneq[0] : -1);
            if (doneq.size() > 0 && doneq[0] == cyc) void'(doneq.pop_front());
         end else if (done !== 1'b0) begin
            chk("done_known", done, 0);
         end else if (doneq.size() > 0 && doneq[0] == cyc) begin
            chk("done_missing", 0, 1);
            void'(doneq.pop_front());
         end
      end
   end

   initial begin
      int t;
      rst_n = 1'b0; ena = 1'b1; tick = 1'b0; clr_ovr = 1'b0;
      bus.load = 1'b0; bus.load_idx = '0; bus.load_x = '0; bus.load_y = '0;
      bus.load_dx = 1'b0; bus.load_dy = 1'b0; bus.load_spd = '0; bus.rd_idx = '0;
      @(posedge clk); #1;
      step_cyc();
      step_cyc();
      rst_n = 1'b1;
      pre_en = 1'b1;
      mon_en = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_bounce", {bus.bounce_x, bus.bounce_y}, 0);
      chk("rst_bidx", bus.bounce_idx, 0);
      rd_exp("rst_obj3", 3, 0, 0);

      // Defaults: every object steps by 1 on both axes.
      tick = 1'b1; step_cyc(); run_idle();
      for (int i = 0; i < N_OBJ; i++) rd_exp("dflt", i, 1, 1);

      // x landing exactly on the wall, then reflecting.
      set_load(2, 157, 5, 0, 0, 3); tick = 1'b1; step_cyc(); run_idle();
      rd_exp("wall_x", 2, 159, 8);
      tick = 1'b1; step_cyc(); run_idle();
      rd_exp("refl_x", 2, 156, 11);

      // y reaching zero while decreasing.
      set_load(1, 10, 2, 0, 1, 3); tick = 1'b1; step_cyc(); run_idle();
      rd_exp("wall_y", 1, 13, 0);
      tick = 1'b1; step_cyc(); run_idle();
      rd_exp("refl_y", 1, 16, 3);

      // Overrun: tick while busy, clear racing a set, then a lone clear.
      tick = 1'b1; step_cyc();
      step_cyc();
      tick = 1'b1; step_cyc();
      chk("ovr_set", overrun, 1);
      tick = 1'b1; clr_ovr = 1'b1; step_cyc();
      chk("ovr_set_wins", overrun, 1);
      run_idle();
      check_all();
      clr_ovr = 1'b1; step_cyc();
      chk("ovr_clr", overrun, 0);

      // Load while busy is dropped; oversized load clamps; zero speed parks on the wall.
      tick = 1'b1; step_cyc();
      set_load(3, 50, 50, 0, 0, 2);
      chk("busy_load_ready", bus.load_ready, 0);
      step_cyc(); run_idle();
      check_all();
      set_load(3, 200, 250, 0, 0, 2); step_cyc();
      rd_exp("clamp", 3, 159, 119);
      set_load(0, 159, 40, 0, 0, 0); tick = 1'b1; step_cyc(); run_idle();
      rd_exp("spd0", 0, 159, 40);

      // Reset in the middle of a sweep.
      tick = 1'b1; step_cyc();
      step_cyc();
      rst_n = 1'b0; step_cyc();
      rst_n = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      check_all();
      rd_exp("abort_obj2", 2, 0, 0);

      // Disabled: tick and load ignored.
      ena = 1'b0; tick = 1'b1; set_load(0, 77, 77, 0, 0, 1); step_cyc();
      chk("ena0_busy", busy, 0);
      ena = 1'b1; step_cyc();
      rd_exp("ena0_obj0", 0, 0, 0);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         t = $urandom_range(0, 99);
         ena = (cyc > busy_end + 1 && t < 8) ? 1'b0 : 1'b1;
         tick = ($urandom_range(0, 5) == 0);
         clr_ovr = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0)
            set_load($urandom_range(0, N_OBJ - 1), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7));
         step_cyc();
      end
      ena = 1'b1;
      run_idle();
      step_cyc();
      check_all();
      chk("events_left", evq.size(), 0);
      chk("done_left", doneq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bounce_multi_core.md
Name: bounce_multi_core

Overview:
- Parametrised, multi-object successor to the single-ball bounce engine inside tt_um_bounce.
- Holds position, direction and speed for N_OBJ objects in a W-bit 2-D field with configurable limits.
- On each frame tick, sweeps the objects round-robin, one per cycle, reflecting each at the walls. Emits bounce events and done/overrun status.
- Sits between the frame-timing logic (tick source) and the pixel/display logic (read port).

Parameters:
- N_OBJ, 4, number of objects (2..16); IDX_W = clog2(N_OBJ), min 1.
- W, 8, coordinate width in bits.
- LIM_X, 159, max x coordinate (< 2^W).
- LIM_Y, 119, max y coordinate (< 2^W).
- SPD_W, 3, speed field width; step per tick is 0..2^SPD_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  enable; low freezes all state (reset still acts)
- tick  in  1  frame tick, single-cycle pulse
- clr_ovr  in  1  clears the overrun flag
- load  in  1  write one object's state
- load_ready  out  1  high when idle (load accepted)
- load_idx  in  IDX_W  object to load
- load_x  in  W  x position
- load_y  in  W  y position
- load_dx  in  1  x direction, 1 = decreasing
- load_dy  in  1  y direction, 1 = decreasing
- load_spd  in  SPD_W  speed, applied to both axes
- rd_idx  in  IDX_W  read select
- rd_x  out  W  x of object rd_idx (combinational from registers)
- rd_y  out  W  y of object rd_idx
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- overrun  out  1  sticky flag: tick arrived while busy
- bounce_x  out  1  x reflection occurred this cycle
- bounce_y  out  1  y reflection occurred this cycle
- bounce_idx  out  IDX_W  object that bounced (valid when bounce_x or bounce_y is high)

Behaviour:
- Reset (rst_n low at a clock edge), synchronous:
  - all x=y=0, dx=dy=0, spd=1
  - busy=0, done=0, overrun=0, bounce_x=bounce_y=0, bounce_idx=0
  - aborts any sweep in progress.
- ena=0: no register changes except reset; tick, load and clr_ovr are ignored.
- States: IDLE, SWEEP(i), i = 0..N_OBJ-1.
- IDLE + tick: go to SWEEP(0) next cycle. busy=1 throughout SWEEP.
- SWEEP(i): object i is updated at the clock edge ending the cycle. bounce_x/bounce_y/bounce_idx are registered and valid the following cycle.
- From SWEEP(N_OBJ-1): return to IDLE. done=1 for exactly one cycle, concurrent with the last bounce outputs. busy=0 in that cycle.
- Latency: tick in cycle T gives done in cycle T+N_OBJ+1.
- Tick while busy: dropped, overrun set to 1; the sweep is unaffected.
- Tick in the same cycle as done (busy=0): accepted, new sweep starts.
- clr_ovr clears overrun; if set and clear occur in the same cycle, set wins.
- Per-axis update, computed in W+1 bits (p = pos, s = spd, L = limit):
  - increasing: if p+s >= L then p=L, dir flips to 1, bounce pulses; else p=p+s.
  - decreasing: if p <= s then p=0, dir flips to 0, bounce pulses; else p=p-s.
  - s=0: no movement and no bounce, even when sitting at a wall.
  - Landing exactly on a wall counts as a bounce.
- Load: accepted only when load_ready=1 (IDLE) and ena=1; ignored otherwise (no queueing).
  - Coordinates above the limit are clamped to LIM_X/LIM_Y.
  - Load and tick in the same IDLE cycle: load is written first, then the sweep uses the loaded value.
  - load_idx >= N_OBJ is ignored.
- rd_idx >= N_OBJ reads 0.

Test Plan:
- Reset then tick, defaults -> busy high cycles T+1..T+4, done at T+5; all objects x=1, y=1; overrun=0; no bounce pulses.
- Load obj2 x=157, y=5, spd=3, dx=0, dy=0, tick -> rd_x(2)=159, y=8; bounce_x=1 with bounce_idx=2 one cycle after SWEEP(2). Next tick -> x=156.
- Load obj1 y=2, dy=1, spd=3, tick -> y=0, dy flips, bounce_y=1 idx 1. Next tick -> y=3.
- Tick at T, second tick at T+2 -> overrun=1, positions advance once only. clr_ovr and tick together while busy -> overrun stays 1. clr_ovr alone -> overrun=0.
- Load while busy -> load_ready=0, state unchanged. Load x=200 while idle -> rd_x=159. Load obj0 spd=0 at x=159 with tick -> no move, no bounce.
- rst_n low during SWEEP(1) -> next cycle busy=0, done=0, all positions 0. ena=0 with tick -> nothing changes.
